// File: rtl/cp0_ctrl.sv
// cp0_ctrl: CP0 register file with timer interrupt and exception/ERET sequencing for the MEM stage
module cp0_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic [31:0] exception_type_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        timer_int_o
);
  localparam logic [4:0] R_BADV = 5'd8, R_COUNT = 5'd9, R_CMP = 5'd11, R_STATUS = 5'd12, R_CAUSE = 5'd13, R_EPC = 5'd14;
  logic [31:0] status, cause, epc, bad_vaddr, count, compare;
  logic        tick, timer_int;
  logic        exc, eret, mtc0, byp;
  logic [31:0] status_w, cause_w;
  assign eret = exception_type_i == 32'he;
  assign exc = exception_type_i != 32'h0 && !eret;
  assign mtc0 = we_i && !exc && !eret;
  assign byp = we_i && waddr_i == raddr_i;
  assign status_w = (wdata_i & 32'h0000_FF03) | 32'h0040_0000;
  assign cause_w = {cause[31:10], wdata_i[9:8], cause[7:0]};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      status    <= STATUS_RST;
      cause     <= '0;
      epc       <= '0;
      bad_vaddr <= '0;
      count     <= '0;
      compare   <= '0;
      tick      <= 1'b0;
      timer_int <= 1'b0;
    end else begin
      tick      <= ~tick;
      count     <= (mtc0 && waddr_i == R_COUNT) ? wdata_i : count + 32'(tick);
      compare   <= (mtc0 && waddr_i == R_CMP) ? wdata_i : compare;
      timer_int <= (mtc0 && waddr_i == R_CMP) ? 1'b0 : (count == compare && compare != '0) ? 1'b1 : timer_int;
      cause[15:10] <= {int_i[5] | timer_int, int_i[4:0]};
      if (mtc0 && waddr_i == R_CAUSE) cause[9:8] <= wdata_i[9:8];
      if (mtc0 && waddr_i == R_STATUS) status <= status_w;
      if (mtc0 && waddr_i == R_EPC) epc <= wdata_i;
      if (eret) status[1] <= 1'b0;
      if (exc) begin
        status[1]  <= 1'b1;
        cause[6:2] <= exception_type_i == 32'h1 ? 5'd0 : exception_type_i[4:0];
        if (!status[1]) begin
          epc       <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
          cause[31] <= in_delayslot_i;
        end
        if (exception_type_i == 32'h4 || exception_type_i == 32'h5) bad_vaddr <= bad_addr_i;
      end
    end
  end
  // Status/Cause outputs stay purely registered so the exception encoder sees no combinational loop
  assign status_o    = status;
  assign cause_o     = cause;
  assign epc_o       = epc;
  assign timer_int_o = timer_int;
  assign flush_o     = !rst_i && exception_type_i != 32'h0;
  assign new_pc_o    = !flush_o ? 32'h0 : !eret ? EXC_VECTOR : (we_i && waddr_i == R_EPC) ? wdata_i : epc;
  always_comb begin
    rdata_o = '0;
    if (!rst_i)
      case (raddr_i)
        R_BADV:   rdata_o = bad_vaddr;
        R_COUNT:  rdata_o = byp ? wdata_i : count;
        R_CMP:    rdata_o = byp ? wdata_i : compare;
        R_STATUS: rdata_o = byp ? status_w : status;
        R_CAUSE:  rdata_o = byp ? cause_w : cause;
        R_EPC:    rdata_o = byp ? wdata_i : epc;
        default:  rdata_o = '0;
      endcase
  end
endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed checks of CP0 registers, timer, exception entry and ERET
module tb_cp0_ctrl;
  logic        clk_i = 1'b0, rst_i, we_i, in_delayslot_i;
  logic [4:0]  waddr_i, raddr_i;
  logic [31:0] wdata_i, exception_type_i, pc_i, bad_addr_i;
  logic [5:0]  int_i;
  logic [31:0] rdata_o, status_o, cause_o, epc_o, new_pc_o;
  logic        flush_o, timer_int_o;
  int n_cmp = 0, n_bad = 0;

  cp0_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .int_i(int_i), .exception_type_i(exception_type_i),
    .pc_i(pc_i), .in_delayslot_i(in_delayslot_i), .bad_addr_i(bad_addr_i),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .flush_o(flush_o),
    .new_pc_o(new_pc_o), .timer_int_o(timer_int_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle();
    we_i = 0; waddr_i = 0; wdata_i = 0; raddr_i = 0; int_i = 0;
    exception_type_i = 0; pc_i = 0; in_delayslot_i = 0; bad_addr_i = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1;
    raddr_i = 12;
    @(negedge clk_i);
    @(negedge clk_i);
    n_cmp++; if (rdata_o !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want %h", rdata_o, 32'h0); end
    rst_i = 0;
    repeat (10) @(negedge clk_i);
    raddr_i = 9; #1;
    n_cmp++; if (rdata_o !== 32'd5) begin n_bad++; $display("FAIL rst_count: got %h want %h", rdata_o, 32'd5); end
    n_cmp++; if (status_o !== 32'h0040_0000) begin n_bad++; $display("FAIL rst_status: got %h want %h", status_o, 32'h0040_0000); end
    n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL rst_flush: got %b want 0", flush_o); end
    n_cmp++; if (timer_int_o !== 1'b0) begin n_bad++; $display("FAIL rst_timer: got %b want 0", timer_int_o); end
    n_cmp++; if (new_pc_o !== 32'h0) begin n_bad++; $display("FAIL rst_newpc: got %h want 0", new_pc_o); end
  endtask

  task automatic test_timer();
    do_reset();
    we_i = 1; waddr_i = 11; wdata_i = 8;
    @(negedge clk_i);
    idle();
    repeat (15) @(negedge clk_i);
    raddr_i = 9; #1;
    n_cmp++; if (rdata_o !== 32'd8) begin n_bad++; $display("FAIL tmr_count8: got %h want %h", rdata_o, 32'd8); end
    n_cmp++; if (timer_int_o !== 1'b0) begin n_bad++; $display("FAIL tmr_early: got %b want 0", timer_int_o); end
    @(negedge clk_i);
    n_cmp++; if (timer_int_o !== 1'b1) begin n_bad++; $display("FAIL tmr_set: got %b want 1", timer_int_o); end
    @(negedge clk_i);
    n_cmp++; if (cause_o[15] !== 1'b1) begin n_bad++; $display("FAIL tmr_ip7: got %b want 1", cause_o[15]); end
    we_i = 1; waddr_i = 11; wdata_i = 20;
    @(negedge clk_i);
    idle();
    n_cmp++; if (timer_int_o !== 1'b0) begin n_bad++; $display("FAIL tmr_clear: got %b want 0", timer_int_o); end
  endtask

  task automatic test_count();
    do_reset();
    we_i = 1; waddr_i = 9; wdata_i = 32'hFFFF_FFFF; raddr_i = 9; #1;
    n_cmp++; if (rdata_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL cnt_bypass: got %h want %h", rdata_o, 32'hFFFF_FFFF); end
    @(negedge clk_i);
    we_i = 1; waddr_i = 8; wdata_i = 32'hDEAD_BEEF; raddr_i = 9; #1;
    n_cmp++; if (rdata_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL cnt_write: got %h want %h", rdata_o, 32'hFFFF_FFFF); end
    @(negedge clk_i);
    we_i = 0; #1;
    n_cmp++; if (rdata_o !== 32'h0) begin n_bad++; $display("FAIL cnt_wrap: got %h want 0", rdata_o); end
    raddr_i = 8; #1;
    n_cmp++; if (rdata_o !== 32'h0) begin n_bad++; $display("FAIL badv_ro: got %h want 0", rdata_o); end
    raddr_i = 5; #1;
    n_cmp++; if (rdata_o !== 32'h0) begin n_bad++; $display("FAIL unmapped: got %h want 0", rdata_o); end
  endtask

  task automatic test_cause_ip();
    do_reset();
    int_i = 6'b10_0101; we_i = 1; waddr_i = 13; wdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    we_i = 0;
    @(negedge clk_i);
    n_cmp++; if (cause_o !== 32'h0000_9700) begin n_bad++; $display("FAIL cause_ip: got %h want %h", cause_o, 32'h0000_9700); end
    exception_type_i = 1; pc_i = 32'h8000_0040;
    @(negedge clk_i);
    idle();
    n_cmp++; if (cause_o[6:2] !== 5'd0) begin n_bad++; $display("FAIL int_code: got %h want 0", cause_o[6:2]); end
    n_cmp++; if (epc_o !== 32'h8000_0040) begin n_bad++; $display("FAIL int_epc: got %h want %h", epc_o, 32'h8000_0040); end
  endtask

  task automatic test_exception();
    do_reset();
    exception_type_i = 4; pc_i = 32'h8000_1000; in_delayslot_i = 1; bad_addr_i = 32'h1234_5671; #1;
    n_cmp++; if (flush_o !== 1'b1) begin n_bad++; $display("FAIL exc_flush: got %b want 1", flush_o); end
    n_cmp++; if (new_pc_o !== 32'hBFC0_0380) begin n_bad++; $display("FAIL exc_newpc: got %h want %h", new_pc_o, 32'hBFC0_0380); end
    @(negedge clk_i);
    idle(); raddr_i = 8; #1;
    n_cmp++; if (epc_o !== 32'h8000_0FFC) begin n_bad++; $display("FAIL exc_epc: got %h want %h", epc_o, 32'h8000_0FFC); end
    n_cmp++; if (cause_o[31] !== 1'b1) begin n_bad++; $display("FAIL exc_bd: got %b want 1", cause_o[31]); end
    n_cmp++; if (cause_o[6:2] !== 5'h4) begin n_bad++; $display("FAIL exc_code: got %h want 4", cause_o[6:2]); end
    n_cmp++; if (rdata_o !== 32'h1234_5671) begin n_bad++; $display("FAIL exc_badv: got %h want %h", rdata_o, 32'h1234_5671); end
    n_cmp++; if (status_o[1] !== 1'b1) begin n_bad++; $display("FAIL exc_exl: got %b want 1", status_o[1]); end
    n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL exc_unflush: got %b want 0", flush_o); end
  endtask

  task automatic test_nested();
    exception_type_i = 32'hc; pc_i = 32'h9000_0000; bad_addr_i = 32'h5555_5555; #1;
    n_cmp++; if (flush_o !== 1'b1) begin n_bad++; $display("FAIL nest_flush: got %b want 1", flush_o); end
    @(negedge clk_i);
    idle(); raddr_i = 8; #1;
    n_cmp++; if (epc_o !== 32'h8000_0FFC) begin n_bad++; $display("FAIL nest_epc: got %h want %h", epc_o, 32'h8000_0FFC); end
    n_cmp++; if (cause_o[6:2] !== 5'hc) begin n_bad++; $display("FAIL nest_code: got %h want c", cause_o[6:2]); end
    n_cmp++; if (cause_o[31] !== 1'b1) begin n_bad++; $display("FAIL nest_bd: got %b want 1", cause_o[31]); end
    n_cmp++; if (rdata_o !== 32'h1234_5671) begin n_bad++; $display("FAIL nest_badv: got %h want %h", rdata_o, 32'h1234_5671); end
  endtask

  task automatic test_eret();
    exception_type_i = 32'he; we_i = 1; waddr_i = 14; wdata_i = 32'h8000_2000; #1;
    n_cmp++; if (flush_o !== 1'b1) begin n_bad++; $display("FAIL eret_flush: got %b want 1", flush_o); end
    n_cmp++; if (new_pc_o !== 32'h8000_2000) begin n_bad++; $display("FAIL eret_newpc: got %h want %h", new_pc_o, 32'h8000_2000); end
    @(negedge clk_i);
    idle(); #1;
    n_cmp++; if (status_o[1] !== 1'b0) begin n_bad++; $display("FAIL eret_exl: got %b want 0", status_o[1]); end
    n_cmp++; if (epc_o !== 32'h8000_0FFC) begin n_bad++; $display("FAIL eret_epc: got %h want %h", epc_o, 32'h8000_0FFC); end
    exception_type_i = 32'he; #1;
    n_cmp++; if (new_pc_o !== 32'h8000_0FFC) begin n_bad++; $display("FAIL eret_epcpc: got %h want %h", new_pc_o, 32'h8000_0FFC); end
    @(negedge clk_i);
    idle();
  endtask

  task automatic test_mtc0_drop();
    exception_type_i = 8; pc_i = 32'h8000_3000; we_i = 1; waddr_i = 12; wdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    idle(); #1;
    n_cmp++; if (status_o !== 32'h0040_0002) begin n_bad++; $display("FAIL drop_status: got %h want %h", status_o, 32'h0040_0002); end
    n_cmp++; if (cause_o[6:2] !== 5'h8) begin n_bad++; $display("FAIL drop_code: got %h want 8", cause_o[6:2]); end
    n_cmp++; if (epc_o !== 32'h8000_3000) begin n_bad++; $display("FAIL drop_epc: got %h want %h", epc_o, 32'h8000_3000); end
    we_i = 1; waddr_i = 12; wdata_i = 32'hFFFF_FFFF; raddr_i = 12; #1;
    n_cmp++; if (rdata_o !== 32'h0040_FF03) begin n_bad++; $display("FAIL st_bypass: got %h want %h", rdata_o, 32'h0040_FF03); end
    n_cmp++; if (status_o !== 32'h0040_0002) begin n_bad++; $display("FAIL st_nobyp: got %h want %h", status_o, 32'h0040_0002); end
    @(negedge clk_i);
    idle(); #1;
    n_cmp++; if (status_o !== 32'h0040_FF03) begin n_bad++; $display("FAIL st_write: got %h want %h", status_o, 32'h0040_FF03); end
  endtask

  task automatic test_mid_reset();
    exception_type_i = 4; pc_i = 32'h8000_4000; bad_addr_i = 32'hAAAA_0000; rst_i = 1; raddr_i = 14; #1;
    n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL mrst_flush: got %b want 0", flush_o); end
    n_cmp++; if (new_pc_o !== 32'h0) begin n_bad++; $display("FAIL mrst_newpc: got %h want 0", new_pc_o); end
    @(negedge clk_i);
    idle(); rst_i = 0; #1;
    n_cmp++; if (status_o !== 32'h0040_0000) begin n_bad++; $display("FAIL mrst_status: got %h want %h", status_o, 32'h0040_0000); end
    n_cmp++; if (cause_o !== 32'h0) begin n_bad++; $display("FAIL mrst_cause: got %h want 0", cause_o); end
    n_cmp++; if (epc_o !== 32'h0) begin n_bad++; $display("FAIL mrst_epc: got %h want 0", epc_o); end
    raddr_i = 8; #1;
    n_cmp++; if (rdata_o !== 32'h0) begin n_bad++; $display("FAIL mrst_badv: got %h want 0", rdata_o); end
    raddr_i = 9; #1;
    n_cmp++; if (rdata_o !== 32'h0) begin n_bad++; $display("FAIL mrst_count: got %h want 0", rdata_o); end
  endtask

  initial begin
    idle();
    rst_i = 1;
    @(negedge clk_i);
    test_reset();
    test_timer();
    test_count();
    test_cause_ip();
    test_exception();
    test_nested();
    test_eret();
    test_mtc0_drop();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
